// File: rtl/dac_table_8x_dbg_pkg.sv
// Shared types and constants for the dac_table_8x debug/deadlock reporting path.
package dac_table_8x_dbg_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      DETECTED = 1'b1
   } state_t;

   localparam int IDX_W         = 4;
   localparam int DEF_THRESHOLD = 1024;

endpackage

// File: rtl/dac_table_8x_persist_cnt.sv
// Persistence qualifier for one monitor: counts consecutive blocked cycles and
// flags the cycle on which the run length reaches THRESHOLD.
module dac_table_8x_persist_cnt
   import dac_table_8x_dbg_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = DEF_THRESHOLD
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic block,
   input  logic clear,
   output logic trip
);

   logic [CNT_W-1:0] cnt;

   // Holding at THRESHOLD keeps a long stall from re-tripping later.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_W'(THRESHOLD)) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear || !enable || !block) begin
         cnt <= '0;
      end else begin
         cnt <= sat_inc(cnt);
      end
   end

   assign trip = enable && block && (cnt == CNT_W'(THRESHOLD - 1));

endmodule

// File: rtl/dac_table_8x_deadlock_reporter.sv
// Qualifies monitor block flags by persistence and latches a sticky deadlock
// report (offender, snapshot, timestamp) with a one-cycle interrupt.
module dac_table_8x_deadlock_reporter
   import dac_table_8x_dbg_pkg::*;
#(
   parameter int N_MON     = 4,
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int TS_W      = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [N_MON-1:0] block_in,
   input  logic             clear,
   output logic             deadlock,
   output logic             irq,
   output logic [IDX_W-1:0] offender_idx,
   output logic [N_MON-1:0] block_snapshot,
   output logic [TS_W-1:0]  detect_time,
   output logic [TS_W-1:0]  timestamp
);

   state_t           state;
   logic [N_MON-1:0] trip;
   logic [IDX_W-1:0] first_idx;
   logic             cnt_clear;

   // A clear only restarts the counters when it actually releases a report.
   assign cnt_clear = (state == DETECTED) && clear;

   for (genvar g = 0; g < N_MON; g++) begin : g_cnt
      dac_table_8x_persist_cnt #(
         .CNT_W     (CNT_W),
         .THRESHOLD (THRESHOLD)
      ) u_cnt (
         .clock   (clock),
         .reset_n (reset_n),
         .enable  (enable),
         .block   (block_in[g]),
         .clear   (cnt_clear),
         .trip    (trip[g])
      );
   end

   always_comb begin
      first_idx = '0;
      for (int i = N_MON - 1; i >= 0; i--) begin
         if (trip[i]) first_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) timestamp <= '0;
      else          timestamp <= timestamp + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RUN;
         deadlock       <= 1'b0;
         irq            <= 1'b0;
         offender_idx   <= '0;
         block_snapshot <= '0;
         detect_time    <= '0;
      end else begin
         irq <= 1'b0;
         case (state)
            RUN: begin
               if (|trip) begin
                  state          <= DETECTED;
                  deadlock       <= 1'b1;
                  irq            <= 1'b1;
                  offender_idx   <= first_idx;
                  block_snapshot <= block_in;
                  detect_time    <= timestamp;
               end
            end
            DETECTED: begin
               if (clear) begin
                  state    <= RUN;
                  deadlock <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
